// File: rtl/megaram_mem_arbiter_pkg.sv
// Shared types and constants for the MegaRAM two-port RAM arbiter.
package megaram_arb_pkg;

    localparam int         ARB_ADDR_W = 27;
    localparam logic [7:0] IDLE_DATA  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic                  rnw;
        logic [ARB_ADDR_W-1:0] addr;
        logic [7:0]            wdata;
    } mem_txn_t;

    function automatic mem_txn_t make_txn(input logic                  rnw,
                                          input logic [ARB_ADDR_W-1:0] addr,
                                          input logic [7:0]            wdata);
        mem_txn_t t;
        t.rnw   = rnw;
        t.addr  = addr;
        t.wdata = wdata;
        return t;
    endfunction

endpackage

// File: rtl/megaram_mem_arbiter_if.sv
// Requester ports A/B plus the external RAM port of the MegaRAM arbiter; the arbiter uses the slave side.
interface megaram_mem_arbiter_if
    import megaram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W
);
    logic              a_req;
    logic              a_rnw;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_wdata;
    logic              a_ack;
    logic [7:0]        a_rdata;

    logic              b_req;
    logic              b_rnw;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_wdata;
    logic              b_ack;
    logic [7:0]        b_rdata;

    logic              mem_req;
    logic              mem_rnw;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    logic              busy;
    logic              timeout_err;

    modport slave (
        input  a_req, a_rnw, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_rnw, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_req, mem_rnw, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output busy, timeout_err
    );

    modport master (
        output a_req, a_rnw, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_rnw, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_req, mem_rnw, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  busy, timeout_err
    );

endinterface

// File: rtl/megaram_mem_arbiter_pick.sv
// Winner selection for the arbiter: A by default, B forced after STARVE_LIMIT consecutive A wins.
module megaram_arb_pick
    import megaram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic grant_a_o,
    output logic grant_b_o,
    output logic grant_o
);

    localparam int               CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             b_forced;

    assign b_forced  = (starve_q == LIMIT);
    assign grant_b_o = sample_i && b_req_i && (!a_req_i || b_forced);
    assign grant_a_o = sample_i && a_req_i && !grant_b_o;
    assign grant_o   = grant_a_o || grant_b_o;

    // Counts A wins taken while B waited; any idle cycle with B quiet forgives the debt.
    always_comb begin
        starve_d = starve_q;
        if (sample_i) begin
            if (grant_b_o || !b_req_i) begin
                starve_d = '0;
            end else if (grant_a_o && !b_forced) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/megaram_mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the cartridge RAM port (IDLE -> WAIT -> RESP).
// Optional WAIT watchdog enabled by defining MEGARAM_ARB_TIMEOUT_EN.
module megaram_mem_arbiter
    import megaram_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int STARVE_LIMIT = 4
`ifdef MEGARAM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input logic                  clk,
    input logic                  reset,
    megaram_mem_arbiter_if.slave bus
);

    localparam logic [1:0]        ST_IDLE   = IDLE;
    localparam logic [1:0]        ST_WAIT   = WAIT;
    localparam logic [1:0]        ST_RESP   = RESP;
    localparam logic [ADDR_W-1:0] ADDR_IDLE = '1;

    logic [1:0] state_q, state_d;
    arb_owner_t owner_q, owner_d;
    mem_txn_t   txn_q, txn_d;
    mem_txn_t   txn_a, txn_b;
    logic       mem_req_q, mem_req_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;
    logic [7:0] cap_data;
    logic       grant_a, grant_b, grant;
    logic       expired;

    assign txn_a = make_txn(bus.a_rnw, bus.a_addr, bus.a_wdata);
    assign txn_b = make_txn(bus.b_rnw, bus.b_addr, bus.b_wdata);

    megaram_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .sample_i  (state_q == ST_IDLE),
        .a_req_i   (bus.a_req),
        .b_req_i   (bus.b_req),
        .grant_a_o (grant_a),
        .grant_b_o (grant_b),
        .grant_o   (grant)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        txn_d     = txn_q;
        mem_req_d = mem_req_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        cap_data  = IDLE_DATA;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d   = grant_a ? OWN_A : OWN_B;
                    txn_d     = grant_b ? txn_b : txn_a;
                    mem_req_d = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Only a completed read returns RAM data; writes and watchdog expiry report IDLE_DATA.
                if (bus.mem_ack || expired) begin
                    if (bus.mem_ack && txn_q.rnw) begin
                        cap_data = bus.mem_rdata;
                    end
                    if (owner_q == OWN_A) begin
                        a_rdata_d = cap_data;
                    end else begin
                        b_rdata_d = cap_data;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_A;
            txn_q     <= make_txn(1'b1, ADDR_IDLE, IDLE_DATA);
            mem_req_q <= 1'b0;
            a_rdata_q <= IDLE_DATA;
            b_rdata_q <= IDLE_DATA;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            txn_q     <= txn_d;
            mem_req_q <= mem_req_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

`ifdef MEGARAM_ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    assign expired = (wait_cnt_q == TO_LAST);

    // A coincident mem_ack beats expiry, so the error only latches on a genuinely silent RAM.
    always_comb begin
        wait_cnt_d    = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
        timeout_err_d = timeout_err_q || ((state_q == ST_WAIT) && expired && !bus.mem_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign expired         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_rnw   = txn_q.rnw;
    assign bus.mem_addr  = txn_q.addr;
    assign bus.mem_wdata = txn_q.wdata;
    assign bus.a_ack     = (state_q == ST_RESP) && (owner_q == OWN_A);
    assign bus.b_ack     = (state_q == ST_RESP) && (owner_q == OWN_B);
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
